// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU round-robin scheduler:
//   - ALU opcode encodings (the ALU itself lives outside the scheduler)
//   - scheduler FSM state encoding
//   - execute-counter width
// ----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ADD   = 3'b000;  // a + b
    localparam logic [2:0] OP_SUB   = 3'b001;  // a - b
    localparam logic [2:0] OP_NOT   = 3'b010;  // ~a
    localparam logic [2:0] OP_AND   = 3'b011;  // a & b
    localparam logic [2:0] OP_OR    = 3'b100;  // a | b
    localparam logic [2:0] OP_XOR   = 3'b101;  // a ^ b
    localparam logic [2:0] OP_NZSUB = 3'b110;  // 1 when a - b != 0
    localparam logic [2:0] OP_EQ    = 3'b111;  // 1 when a == b

    // Execute counter width; EXEC_CYCLES is limited to 1..15 so it never wraps.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant, purely combinational.
//   i_valid  [1:0]  request valids, bit N = requester N
//   i_last          index of the requester served most recently
//   o_grant  [1:0]  one-hot grant (all zero when nothing is valid)
// A lone requester always wins; on contention the one not served last wins.
// ----------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case can leave it unassigned (no latch).
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_rr_sched.sv
// ----------------------------------------------------------------------------
// alu_rr_sched
// Shares one external combinational ALU between two requesters. A command is
// granted round-robin, its operands are registered onto alu_* and held for
// EXEC_CYCLES cycles, then the ALU result is captured with zero/negative flags
// and offered on a valid/ready response port tagged with the requester index.
// One command in flight at a time.
//
// Parameters
//   W            operand/result width
//   EXEC_CYCLES  cycles alu_* are held before capture (1..15)
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op         command port of requester N (N = 0, 1)
//   alu_a, alu_b, alu_op            registered operands to the ALU
//   alu_result                      combinational ALU output
//   resp_valid/ready                response handshake
//   resp_result, resp_id,
//   resp_zero, resp_neg             captured result, issuer and flags
//   busy                            a command is executing or awaiting pickup
// ----------------------------------------------------------------------------
module alu_rr_sched
    import alu_pkg::*;
#(
    parameter int W           = 4,
    parameter int EXEC_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,

    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [2:0]   req0_op,

    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic [2:0]   req1_op,

    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_result,

    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_result,
    output logic         resp_id,
    output logic         resp_zero,
    output logic         resp_neg,

    output logic         busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXEC_CYCLES - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_last;      // requester served most recently
    logic               r_id;        // issuer of the command in flight
    logic [W-1:0]       r_alu_a;
    logic [W-1:0]       r_alu_b;
    logic [2:0]         r_alu_op;
    logic [W-1:0]       r_result;
    logic               r_resp_id;
    logic               r_zero;
    logic               r_neg;

    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_done;
    logic               w_resp_hs;

    rr_arb2 u_arb (
        .i_valid (({req1_valid, req0_valid})),
        .i_last  (r_last),
        .o_grant (w_grant)
    );

    // The arbiter only grants a valid requester, so any grant in IDLE is a handshake.
    assign w_accept  = (r_state == S_IDLE) && (w_grant != 2'b00);
    assign w_done    = (r_state == S_EXEC) && (r_cnt == CNT_LAST);
    assign w_resp_hs = (r_state == S_RESP) && resp_ready;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)  w_state_nxt = S_EXEC;
            S_EXEC:  if (w_done)    w_state_nxt = S_RESP;
            S_RESP:  if (w_resp_hs) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: the datapath registers are reset too, because every output,
        // including alu_* and resp_*, must read 0 straight out of reset.
        if (rst) begin
            r_cnt     <= '0;
            r_last    <= 1'b1;   // "last served = 1" makes requester 0 win the first tie
            r_id      <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_result  <= '0;
            r_resp_id <= 1'b0;
            r_zero    <= 1'b0;
            r_neg     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_id     <= w_grant[1];
                r_alu_a  <= w_grant[1] ? req1_a  : req0_a;
                r_alu_b  <= w_grant[1] ? req1_b  : req0_b;
                r_alu_op <= w_grant[1] ? req1_op : req0_op;
                r_cnt    <= '0;
            end

            if (r_state == S_EXEC) begin
                r_cnt <= r_cnt + 1'b1;
            end

            // Flags are taken from the captured value so they stay 0 in reset
            // and always agree with resp_result.
            if (w_done) begin
                r_result  <= alu_result;
                r_zero    <= (alu_result == '0);
                r_neg     <= alu_result[W-1];
                r_resp_id <= r_id;
                r_last    <= r_id;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign req0_ready  = (r_state == S_IDLE) && w_grant[0];
    assign req1_ready  = (r_state == S_IDLE) && w_grant[1];

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_op      = r_alu_op;

    assign resp_valid  = (r_state == S_RESP);
    assign resp_result = r_result;
    assign resp_id     = r_resp_id;
    assign resp_zero   = r_zero;
    assign resp_neg    = r_neg;

    assign busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_alu_rr_sched
// Directed bench for alu_rr_sched. Two instances share the stimulus:
// u_dut1 with EXEC_CYCLES=1 and u_dut3 with EXEC_CYCLES=3. Each drives its own
// copy of a reference ALU built from alu_model().
// ----------------------------------------------------------------------------
module tb_alu_rr_sched;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst;

    logic       req0_valid, req1_valid, resp_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_op, req1_op;

    // u_dut1 outputs
    logic       req0_ready, req1_ready, resp_valid, resp_id, resp_zero, resp_neg, busy;
    logic [3:0] alu_a, alu_b, alu_result, resp_result;
    logic [2:0] alu_op;

    // u_dut3 outputs
    logic       req0_ready_3, req1_ready_3, resp_valid_3, resp_id_3, resp_zero_3, resp_neg_3, busy_3;
    logic [3:0] alu_a_3, alu_b_3, alu_result_3, resp_result_3;
    logic [2:0] alu_op_3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [2:0] op);
        logic [3:0] diff;
        diff = a - b;
        case (op)
            OP_ADD:   return a + b;
            OP_SUB:   return diff;
            OP_NOT:   return ~a;
            OP_AND:   return a & b;
            OP_OR:    return a | b;
            OP_XOR:   return a ^ b;
            OP_NZSUB: return {3'b000, diff != 4'd0};
            default:  return {3'b000, a == b};
        endcase
    endfunction

    assign alu_result   = alu_model(alu_a, alu_b, alu_op);
    assign alu_result_3 = alu_model(alu_a_3, alu_b_3, alu_op_3);

    alu_rr_sched #(.W(4), .EXEC_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_id(resp_id), .resp_zero(resp_zero), .resp_neg(resp_neg), .busy(busy)
    );

    alu_rr_sched #(.W(4), .EXEC_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready_3), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready_3), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_op(alu_op_3), .alu_result(alu_result_3),
        .resp_valid(resp_valid_3), .resp_ready(resp_ready), .resp_result(resp_result_3),
        .resp_id(resp_id_3), .resp_zero(resp_zero_3), .resp_neg(resp_neg_3), .busy(busy_3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit rq, input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        if (rq) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
        end
    endtask

    // Called just after the accept edge. Counts cycles from accept until
    // resp_valid, checking the ALU operands stay put while executing.
    task automatic wait_resp(input bit d3, input logic [3:0] ea, input logic [3:0] eb,
                             input logic [2:0] eop, output int lat);
        lat = 1;
        while (!(d3 ? resp_valid_3 : resp_valid) && lat < 20) begin
            check("exec_alu_a",  d3 ? alu_a_3  : alu_a,  ea);
            check("exec_alu_b",  d3 ? alu_b_3  : alu_b,  eb);
            check("exec_alu_op", d3 ? alu_op_3 : alu_op, eop);
            tick();
            lat++;
        end
        check("resp_valid_seen", d3 ? resp_valid_3 : resp_valid, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic [3:0] ra, rb, exp_r;

        rst = 1'b1;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;
        resp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req0_ready",  req0_ready,  0);
        check("rst_resp_valid",  resp_valid,  0);
        check("rst_busy",        busy,        0);
        check("rst_alu_a",       alu_a,       0);
        check("rst_alu_op",      alu_op,      0);
        check("rst_resp_result", resp_result, 0);
        check("rst_resp_zero",   resp_zero,   0);
        check("rst_resp_id",     resp_id,     0);
        rst = 1'b0;
        tick();

        // 1: req0 3+4, EXEC_CYCLES=1
        resp_ready = 1'b1;
        issue(0, 4'd3, 4'd4, OP_ADD);
        #1;
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        check("t1_busy", busy, 1);
        wait_resp(0, 4'd3, 4'd4, OP_ADD, lat);
        check("t1_latency", lat, 2);
        check("t1_result",  resp_result, 7);
        check("t1_id",      resp_id,     0);
        check("t1_zero",    resp_zero,   0);
        check("t1_neg",     resp_neg,    0);
        tick();
        check("t1_valid_drop", resp_valid, 0);
        check("t1_busy_drop",  busy,       0);

        // 2: both valid, six rounds alternate starting with requester 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(0, 4'd1, 4'd1, OP_ADD);
        issue(1, 4'd6, 4'd3, OP_SUB);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_one_ready", req0_ready & req1_ready, 0);
            check("t2_req0_ready", req0_ready, (i % 2) == 0);
            check("t2_req1_ready", req1_ready, (i % 2) == 1);
            tick();
            if ((i % 2) == 0) wait_resp(0, 4'd1, 4'd1, OP_ADD, lat);
            else              wait_resp(0, 4'd6, 4'd3, OP_SUB, lat);
            check("t2_id",     resp_id,     i % 2);
            check("t2_result", resp_result, ((i % 2) == 0) ? 2 : 3);
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();

        // 3: req1 5-5 with response backpressure for 4 cycles
        resp_ready = 1'b0;
        issue(1, 4'd5, 4'd5, OP_SUB);
        #1;
        check("t3_req1_ready", req1_ready, 1);
        tick();
        wait_resp(0, 4'd5, 4'd5, OP_SUB, lat);
        check("t3_latency", lat, 2);
        for (int i = 0; i < 4; i++) begin
            check("t3_hold_valid",  resp_valid,  1);
            check("t3_hold_result", resp_result, 0);
            check("t3_hold_zero",   resp_zero,   1);
            check("t3_hold_neg",    resp_neg,    0);
            check("t3_hold_id",     resp_id,     1);
            check("t3_req1_low",    req1_ready,  0);
            check("t3_req0_low",    req0_ready,  0);
            tick();
        end
        resp_ready = 1'b1;
        req1_valid = 1'b0;
        tick();
        check("t3_valid_drop", resp_valid, 0);

        // 4: EXEC_CYCLES=3, 2-7 -> 4'b1011
        rst = 1'b1;
        tick();
        rst = 1'b0;
        issue(0, 4'd2, 4'd7, OP_SUB);
        #1;
        check("t4_req0_ready", req0_ready_3, 1);
        tick();
        req0_valid = 1'b0;
        wait_resp(1, 4'd2, 4'd7, OP_SUB, lat);
        check("t4_latency", lat, 4);
        check("t4_result",  resp_result_3, 4'b1011);
        check("t4_neg",     resp_neg_3,    1);
        check("t4_zero",    resp_zero_3,   0);
        check("t4_id",      resp_id_3,     0);
        tick();
        check("t4_valid_drop", resp_valid_3, 0);
        tick();

        // 5: reset during EXEC abandons the command
        issue(0, 4'd9, 4'd1, OP_ADD);
        tick();
        req0_valid = 1'b0;
        check("t5_busy_exec", busy, 1);
        rst = 1'b1;
        tick();
        check("t5_busy_after_rst",  busy,       0);
        check("t5_valid_after_rst", resp_valid, 0);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("t5_no_resp", resp_valid, 0);
        end
        issue(0, 4'd4, 4'd4, OP_EQ);
        issue(1, 4'd4, 4'd4, OP_XOR);
        #1;
        check("t5_req0_pref", req0_ready, 1);
        check("t5_req1_pref", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_resp(0, 4'd4, 4'd4, OP_EQ, lat);
        check("t5_id",     resp_id,     0);
        check("t5_result", resp_result, 1);
        tick();

        // 6: sweep all ops with random operands, then a wrap-around add
        for (int op = 0; op < 9; op++) begin
            if (op < 8) begin
                ra = 4'($urandom_range(15));
                rb = 4'($urandom_range(15));
            end else begin
                ra = 4'd15;
                rb = 4'd1;
            end
            exp_r = alu_model(ra, rb, 3'(op % 8));
            issue(0, ra, rb, 3'(op % 8));
            tick();
            req0_valid = 1'b0;
            wait_resp(0, ra, rb, 3'(op % 8), lat);
            check("t6_result", resp_result, exp_r);
            check("t6_zero",   resp_zero,   exp_r == 4'd0);
            check("t6_neg",    resp_neg,    exp_r[3]);
            tick();
        end
        check("t6_wrap_zero", resp_zero, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
